// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: stage register indices and write enables in, stall/flush/forward controls out.
// The master side is the pipeline datapath; the slave side is hazard_ctrl.
interface hazard_ctrl_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [4:0] RdM;
    logic [4:0] RdW;
    logic       RegWriteE;
    logic       RegWriteM;
    logic       RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE;
    logic       MemReqM;
    logic       MemReadyM;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;
    logic       FlushW;
    logic       MemErr;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
        output MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemErr
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
        input  MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemErr
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline stall/flush/forward control plus data-memory wait FSM with timeout (HAZARD_FWD_EN selects forwarding vs RAW stall).
// Latency: all controls combinational, same cycle; only FSM state, wait counter and MemErr are registered.
// Backpressure: slow memory freezes F/D/E/M and bubbles WB; a MEM_TIMEOUT overrun halts the front end until rst.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_err_q, mem_err_d;
    logic               mem_stall;
    logic               data_hazard;
    logic [1:0]         fwd_a, fwd_b;
    logic               stall_f, stall_d, stall_e, stall_m;
    logic               flush_d, flush_e, flush_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_stall = hz.MemReqM & ~hz.MemReadyM;
                if (mem_stall) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                mem_stall = ~hz.MemReadyM;
                if (hz.MemReadyM) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Counting the IDLE request cycle, this is the last of MEM_TIMEOUT stalled cycles.
                    if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state_d   = S_ERR;
                        mem_err_d = 1'b1;
                    end
                end
            end
            S_ERR: begin
                mem_err_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef HAZARD_FWD_EN
    logic fwd_unused;
    assign fwd_unused = hz.RegWriteE;

    assign data_hazard = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                         ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)) && !hz.PCSrcE;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E))
                fwd_a = 2'b10;
            else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E))
                fwd_a = 2'b01;
            if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E))
                fwd_b = 2'b10;
            else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E))
                fwd_b = 2'b01;
        end
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^{hz.Rs1E, hz.Rs2E, hz.RdW, hz.RegWriteW, hz.ResultSrcE};

    // Write-first register file covers the WB producer, so only EX and MEM producers stall.
    assign data_hazard = !hz.PCSrcE &&
        ((hz.RegWriteE && (hz.RdE != 5'd0) && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D))) ||
         (hz.RegWriteM && (hz.RdM != 5'd0) && ((hz.RdM == hz.Rs1D) || (hz.RdM == hz.Rs2D))));

    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (state_q == S_ERR) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mem_stall) begin
            // A resolved branch waits here; it is seen again once EX is released.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hz.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (data_hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.ForwardAE = fwd_a;
    assign hz.ForwardBE = fwd_b;
    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.StallE    = stall_e;
    assign hz.StallM    = stall_m;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.FlushW    = flush_w;
    assign hz.MemErr    = mem_err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: expected control vectors are queued as stimulus is applied and compared at the following negedge.
module tb_hazard_ctrl;
    localparam int TO = 16;

    typedef struct {
        string       tag;
        logic [12:0] ctl;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     stall_seen = 0;
    string  cur_tag;

    // Reference memory-wait state, kept as a count of stalled cycles.
    bit     m_err;
    bit     m_wait;
    int     m_stalls;

    always #5 clk = ~clk;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] observed();
        return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushW, hz.MemErr};
    endfunction

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction
`endif

    function automatic logic [12:0] model_out();
        logic [1:0] fa, fb;
        logic sf, sd, se, sm, fd, fe, fw, me, mstall, hzd;
        fa = 2'b00; fb = 2'b00;
        sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fw = 0; me = 0;
        if (rst) begin
            fd = 1; fe = 1;
        end else begin
`ifdef HAZARD_FWD_EN
            fa  = fwd_sel(hz.Rs1E);
            fb  = fwd_sel(hz.Rs2E);
            hzd = !hz.PCSrcE && hz.ResultSrcE == 2'b01 && hz.RdE != 0 &&
                  (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
`else
            hzd = !hz.PCSrcE &&
                  ((hz.RegWriteE && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D)) ||
                   (hz.RegWriteM && hz.RdM != 0 && (hz.RdM == hz.Rs1D || hz.RdM == hz.Rs2D)));
`endif
            mstall = !m_err && !hz.MemReadyM && (m_wait || hz.MemReqM);
            if (m_err) begin
                sf = 1; sd = 1; fe = 1; fw = 1; me = 1;
            end else if (mstall) begin
                sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
            end else if (hz.PCSrcE) begin
                fd = 1; fe = 1;
            end else if (hzd) begin
                sf = 1; sd = 1; fe = 1;
            end
        end
        return {fa, fb, sf, sd, se, sm, fd, fe, fw, me};
    endfunction

    task automatic model_tick();
        if (rst) begin
            m_err = 0; m_wait = 0; m_stalls = 0;
        end else if (!m_err) begin
            if (!hz.MemReadyM && (m_wait || hz.MemReqM)) begin
                m_stalls++;
                m_wait = 1;
                if (m_stalls >= TO) m_err = 1;
            end else begin
                m_wait = 0;
                m_stalls = 0;
            end
        end
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.tag = $sformatf("%s[%0d]", cur_tag, i);
            e.ctl = model_out();
            sb.push_back(e);
            @(posedge clk);
            model_tick();
            #1;
        end
    endtask

    task automatic idle_inputs();
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
        hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.ResultSrcE = 2'b00; hz.PCSrcE = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, {19'd0, observed()}, {19'd0, e.ctl});
            if (hz.StallM) stall_seen++;
        end
    end

    initial begin
        int base;
        rst = 1'b1;
        m_err = 0; m_wait = 0; m_stalls = 0;
        idle_inputs();
        @(posedge clk); #1;

        cur_tag = "reset"; step(2);
        rst = 1'b0;
        cur_tag = "idle"; step(1);

        cur_tag = "fwd_mem";
        hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1; step(1);
        cur_tag = "fwd_wb"; hz.RdM = 0; step(1);
        cur_tag = "fwd_b_wb"; hz.Rs1E = 9; hz.Rs2E = 5; step(1);
        cur_tag = "fwd_x0"; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdW = 0; hz.RegWriteM = 1; step(1);
        idle_inputs();

        cur_tag = "lw_use";
        hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7; hz.RegWriteE = 1; step(1);
        cur_tag = "lw_branch"; hz.PCSrcE = 1; step(1);
        cur_tag = "lw_x0"; hz.PCSrcE = 0; hz.RdE = 0; hz.Rs2D = 0; step(1);
        idle_inputs();
        cur_tag = "raw_mem"; hz.RegWriteM = 1; hz.RdM = 3; hz.Rs1D = 3; step(1);
        idle_inputs();

        base = stall_seen;
        cur_tag = "wait3"; hz.MemReqM = 1; hz.MemReadyM = 0; step(3);
        cur_tag = "wait3_done"; hz.MemReadyM = 1; step(1);
        chk("wait3_len", stall_seen - base, 3);

        base = stall_seen;
        cur_tag = "b2b"; hz.MemReadyM = 0; step(2);
        cur_tag = "b2b_done"; hz.MemReadyM = 1; step(1);
        chk("b2b_len", stall_seen - base, 2);
        idle_inputs();

        cur_tag = "concurrent";
        hz.MemReqM = 1; hz.PCSrcE = 1; hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
        step(2);
        cur_tag = "concurrent_rel"; hz.MemReadyM = 1; step(1);
        idle_inputs();

        base = stall_seen;
        cur_tag = "ready_same"; hz.MemReqM = 1; hz.MemReadyM = 1; step(1);
        chk("ready_same_len", stall_seen - base, 0);

        cur_tag = "wait_rst"; hz.MemReadyM = 0; step(5);
        cur_tag = "mid_rst"; rst = 1'b1; step(1);
        rst = 1'b0;
        base = stall_seen;
        cur_tag = "post_rst"; hz.MemReadyM = 1; step(1);
        chk("post_rst_len", stall_seen - base, 0);

        base = stall_seen;
        cur_tag = "timeout"; hz.MemReadyM = 0; step(TO + 4);
        chk("timeout_len", stall_seen - base, TO);
        cur_tag = "err_hold"; hz.MemReqM = 0; hz.MemReadyM = 1; hz.PCSrcE = 1; step(2);
        idle_inputs();
        cur_tag = "err_rst"; rst = 1'b1; step(1);
        rst = 1'b0;
        cur_tag = "after_err"; step(1);

        @(negedge clk); #1;
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
